// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter sharing one uart_tx among N_SRC sources, with a stall watchdog.
module uart_tx_arbiter #(
  parameter int N_SRC       = 2,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_SRC-1:0]   src_req,
  input  logic [N_SRC-1:0]   src_valid,
  input  logic [8*N_SRC-1:0] src_data,
  input  logic [N_SRC-1:0]   src_last,
  output logic [N_SRC-1:0]   src_ready,
  output logic [N_SRC-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               tx_go,
  input  logic               tx_busy,
  output logic               pkt_done,
  output logic               timeout_err
);
  localparam int IW = $clog2(N_SRC);
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, SEND, DRAIN} state_t;
  state_t state, state_n;
  logic [IW-1:0] rr_ptr, rr_n, g_idx, g_n, pick;
  logic [IW:0] cand;
  logic [N_SRC-1:0] grant_n;
  logic [TW-1:0] timer, timer_n;
  logic [7:0] tx_data_n, sel_data;
  logic tx_go_n, last_q, last_n, pkt_done_n, timeout_n, found, sel_valid, sel_last;
  assign sel_valid = src_valid[g_idx];
  assign sel_last  = src_last[g_idx];
  assign sel_data  = src_data[{g_idx, 3'b000} +: 8];
  assign src_ready = (state == FETCH) ? grant & src_valid : '0;
  // Scan downwards so the source closest after rr_ptr is the last (winning) assignment.
  always_comb begin
    pick = rr_ptr;
    found = 1'b0;
    cand = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      cand = cand >= (IW+1)'(N_SRC) ? cand - (IW+1)'(N_SRC) : cand;
      if (src_req[cand[IW-1:0]]) begin
        pick = cand[IW-1:0];
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    grant_n = grant;
    rr_n = rr_ptr;
    g_n = g_idx;
    timer_n = timer;
    tx_data_n = tx_data;
    tx_go_n = tx_go;
    last_n = last_q;
    pkt_done_n = 1'b0;
    timeout_n = 1'b0;
    case (state)
      IDLE: if (found) begin
        state_n = FETCH;
        g_n = pick;
        grant_n = N_SRC'(1) << pick;
        timer_n = '0;
      end
      FETCH: if (sel_valid) begin
        tx_data_n = sel_data;
        last_n = sel_last;
        tx_go_n = 1'b1;
        state_n = SEND;
      end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
        timeout_n = 1'b1;
        grant_n = '0;
        rr_n = g_idx;
        state_n = IDLE;
      end else begin
        timer_n = timer + TW'(1);
      end
      SEND: if (tx_busy) begin
        tx_go_n = 1'b0;
        state_n = DRAIN;
      end
      DRAIN: if (!tx_busy) begin
        if (last_q) begin
          pkt_done_n = 1'b1;
          grant_n = '0;
          rr_n = g_idx;
          state_n = IDLE;
        end else begin
          timer_n = '0;
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      rr_ptr <= IW'(N_SRC - 1);
      g_idx <= '0;
      timer <= '0;
      tx_data <= '0;
      tx_go <= 1'b0;
      last_q <= 1'b0;
      pkt_done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      rr_ptr <= rr_n;
      g_idx <= g_n;
      timer <= timer_n;
      tx_data <= tx_data_n;
      tx_go <= tx_go_n;
      last_q <= last_n;
      pkt_done <= pkt_done_n;
      timeout_err <= timeout_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with packet sources and a uart_tx busy model around uart_tx_arbiter.
module tb_uart_tx_arbiter;
  localparam int BL = 10;
  logic clk = 1'b0, reset_n = 1'b0, tx_busy = 1'b0;
  logic [1:0] src_req = '0, src_valid = '0, src_last = '0, src_ready, grant;
  logic [15:0] src_data = '0;
  logic [7:0] tx_data;
  logic tx_go, pkt_done, timeout_err;
  int errors = 0, checks = 0, cyc = 0;
  logic [7:0] mem [2][8];
  int len [2], pos [2], stall_at [2];
  bit active [2], reload [2];
  int rdy_cnt [2];
  int go_cnt, overlap, unstable, done_cnt, to_cnt, bad_rdy, done_cyc, to_cyc, fall_cyc, busy_lat, phase, bcnt;
  logic [1:0] acc, grant_prev, grant_at_to;
  logic go_prev, busy_prev, go_s;
  logic [7:0] data_prev;
  logic [7:0] txq [$];
  int gq [$];
  int n;

  uart_tx_arbiter #(.N_SRC(2), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .reset_n(reset_n), .src_req(src_req), .src_valid(src_valid),
    .src_data(src_data), .src_last(src_last), .src_ready(src_ready), .grant(grant),
    .tx_data(tx_data), .tx_go(tx_go), .tx_busy(tx_busy), .pkt_done(pkt_done),
    .timeout_err(timeout_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      bit have;
      have = active[i] && pos[i] < len[i];
      src_req[i] = have;
      src_valid[i] = have && grant[i] && pos[i] != stall_at[i];
      src_data[8*i +: 8] = have ? mem[i][pos[i]] : 8'h00;
      src_last[i] = have && pos[i] == len[i] - 1;
    end
  endtask

  task automatic load(input int i, input int cnt, input logic [63:0] b, input int stall);
    for (int k = 0; k < cnt; k++) mem[i][k] = b[8*k +: 8];
    len[i] = cnt;
    pos[i] = 0;
    stall_at[i] = stall;
    active[i] = 1'b1;
    drive();
  endtask

  task automatic clear();
    rdy_cnt[0] = 0; rdy_cnt[1] = 0;
    go_cnt = 0; overlap = 0; unstable = 0; done_cnt = 0; to_cnt = 0;
    txq.delete();
    gq.delete();
  endtask

  // Monitor samples at negedge; sources and the uart_tx model react 1ns after posedge.
  task automatic tick();
    @(negedge clk);
    acc = src_ready;
    if ((src_ready & ~grant) != 2'b00) bad_rdy++;
    for (int i = 0; i < 2; i++) if (src_ready[i]) rdy_cnt[i]++;
    if (tx_go && !go_prev) txq.push_back(tx_data);
    if (tx_go) go_cnt++;
    if (tx_go && go_prev && tx_data != data_prev) unstable++;
    if (tx_go && tx_busy) overlap++;
    if (pkt_done) begin done_cnt++; done_cyc = cyc; end
    if (timeout_err) begin to_cnt++; to_cyc = cyc; grant_at_to = grant; end
    if (grant != 2'b00 && grant_prev == 2'b00) gq.push_back(grant[1] ? 1 : 0);
    if (busy_prev && !tx_busy) fall_cyc = cyc;
    go_prev = tx_go; data_prev = tx_data; grant_prev = grant; busy_prev = tx_busy; go_s = tx_go;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) if (acc[i]) begin
      pos[i]++;
      if (pos[i] == len[i] && reload[i]) begin pos[i] = 0; reload[i] = 1'b0; end
    end
    if (!reset_n) begin
      phase = 0; tx_busy = 1'b0;
    end else case (phase)
      0: if (go_s) begin
        if (busy_lat <= 1) begin tx_busy = 1'b1; bcnt = BL - 1; phase = 2; end
        else begin bcnt = busy_lat - 2; phase = 1; end
      end
      1: if (bcnt == 0) begin tx_busy = 1'b1; bcnt = BL - 1; phase = 2; end else bcnt--;
      default: if (bcnt == 0) begin tx_busy = 1'b0; phase = 0; end else bcnt--;
    endcase
    drive();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    active[0] = 1'b0; active[1] = 1'b0; reload[0] = 1'b0; reload[1] = 1'b0;
    drive();
    tick();
    tick();
    clear();
    reset_n = 1'b1;
  endtask

  task automatic wait_done(input int target, input int bound, input string tag);
    int w = 0;
    while (done_cnt < target && w < bound) begin tick(); w++; end
    chk(tag, done_cnt, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    busy_lat = 1; phase = 0; bcnt = 0; bad_rdy = 0;
    go_prev = 0; busy_prev = 0; grant_prev = '0; data_prev = '0; go_s = 0;
    len[0] = 0; len[1] = 0; pos[0] = 0; pos[1] = 0; stall_at[0] = -1; stall_at[1] = -1;
    clear();
    reset_n = 1'b0;
    tick();
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_ready", src_ready, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_go", tx_go, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_timeout", timeout_err, 0);

    // Single source, "A090\n"
    do_reset();
    load(0, 5, 64'h0A30393041, -1);
    n = 0;
    while (grant == 2'b00 && n < 20) begin tick(); n++; end
    chk("t1_grant_latency", n, 1);
    chk("t1_grant", grant, 2'b01);
    wait_done(1, 400, "t1_done");
    chk("t1_ready_pulses", rdy_cnt[0], 5);
    chk("t1_bytes", txq.size(), 5);
    chk("t1_b0", txq[0], 8'h41);
    chk("t1_b1", txq[1], 8'h30);
    chk("t1_b2", txq[2], 8'h39);
    chk("t1_b3", txq[3], 8'h30);
    chk("t1_b4", txq[4], 8'h0A);
    chk("t1_done_after_busy_fall", done_cyc - fall_cyc, 1);
    tick();
    chk("t1_grant_released", grant, 0);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_no_timeout", to_cnt, 0);

    // Both sources requesting straight out of reset
    do_reset();
    load(0, 3, 64'h131211, -1);
    load(1, 3, 64'h232221, -1);
    wait_done(2, 800, "t2_done");
    chk("t2_first_owner", gq[0], 0);
    chk("t2_second_owner", gq[1], 1);
    chk("t2_b0", txq[0], 8'h11);
    chk("t2_b2", txq[2], 8'h13);
    chk("t2_b3", txq[3], 8'h21);
    chk("t2_b5", txq[5], 8'h23);

    // Source 0 re-requests at once; source 1 must still go next
    clear();
    reload[0] = 1'b1;
    load(0, 3, 64'h333231, -1);
    load(1, 2, 64'h4241, -1);
    wait_done(3, 1200, "t3_done");
    chk("t3_owner0", gq[0], 0);
    chk("t3_owner1", gq[1], 1);
    chk("t3_owner2", gq[2], 0);
    chk("t3_b3", txq[3], 8'h41);
    chk("t3_b5", txq[5], 8'h31);

    // Stall after one byte triggers the watchdog
    do_reset();
    load(0, 3, 64'h535251, 1);
    n = 0;
    while (grant == 2'b00 && n < 20) begin tick(); n++; end
    load(1, 2, 64'h6261, -1);
    n = 0;
    while (to_cnt == 0 && n < 400) begin tick(); n++; end
    chk("t4_timeout_seen", to_cnt, 1);
    // FETCH is entered the cycle after busy is seen low.
    chk("t4_timeout_delay", to_cyc - (fall_cyc + 1), 100);
    chk("t4_grant_at_timeout", grant_at_to, 0);
    chk("t4_no_done", done_cnt, 0);
    chk("t4_next_grant", grant, 2'b10);
    active[0] = 1'b0;
    drive();
    wait_done(1, 400, "t4_src1_done");
    chk("t4_src0_bytes", rdy_cnt[0], 1);
    chk("t4_src1_bytes", rdy_cnt[1], 2);
    chk("t4_timeout_pulses", to_cnt, 1);

    // uart_tx slow to raise busy
    clear();
    busy_lat = 4;
    load(0, 1, 64'h77, -1);
    wait_done(1, 200, "t5_done");
    chk("t5_go_cycles", go_cnt, 5);
    chk("t5_go_busy_overlap", overlap, 1);
    chk("t5_data_stable", unstable, 0);
    chk("t5_byte", txq[0], 8'h77);

    // Reset in SEND of byte 3
    clear();
    busy_lat = 6;
    load(0, 5, 64'h8584838281, -1);
    n = 0;
    while (rdy_cnt[0] < 3 && n < 300) begin tick(); n++; end
    chk("t6_in_send_go", tx_go, 1);
    chk("t6_in_send_data", tx_data, 8'h83);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_go", tx_go, 0);
    chk("t6_async_grant", grant, 0);
    active[0] = 1'b0; active[1] = 1'b0;
    drive();
    tick();
    tick();
    clear();
    reset_n = 1'b1;
    repeat (5) tick();
    chk("t6_not_resumed_go", go_cnt, 0);
    chk("t6_not_resumed_ready", rdy_cnt[0], 0);
    chk("t6_idle_grant", grant, 0);
    busy_lat = 1;
    load(0, 1, 64'h91, -1);
    load(1, 1, 64'hA1, -1);
    wait_done(2, 400, "t6_done");
    chk("t6_first_owner", gq[0], 0);
    chk("t6_second_owner", gq[1], 1);
    chk("t6_first_byte", txq[0], 8'h91);

    chk("no_foreign_ready", bad_rdy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
